chunked_add_sub: RTL and testbench

Parametrised multi-cycle add/subtract unit, the successor to the single-cycle adder.
- Processes operands CHUNK_WIDTH bits per clock using a registered carry chain, so wide operands do not need a long combinational path.
- Supports add/sub, signed/unsigned overflow detection and optional saturation.
- Sits in the datapath behind the sequencer using a start/busy/complete handshake.

---
 rtl/arith_pkg.sv | 35 +++
 rtl/adder_chunk.sv | 14 +
 rtl/chunked_add_sub.sv | 148 ++++++++++++++
 tb/tb_chunked_add_sub.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and helpers for the chunked add/subtract datapath.
package arith_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic op_sub;
    logic signed_mode;
    logic saturate;
  } op_cfg_t;

  localparam int MAX_WIDTH = 256;

  // Clamp constant for the low 'width' bits: all ones / zero for unsigned add / sub,
  // most-positive or most-negative two's complement value for signed.
  function automatic logic [MAX_WIDTH-1:0] sat_value(input logic signed_mode,
                                                    input logic op_sub,
                                                    input logic a_msb,
                                                    input int   width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width - 1) begin
        v[i] = signed_mode ? ~a_msb : ~op_sub;
      end else if (i == width - 1) begin
        v[i] = signed_mode ? a_msb : ~op_sub;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-wide adder slice with carry in and carry out.
module adder_chunk #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, carry_i};

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract unit: one CHUNK_WIDTH slice per clock through a registered
// carry, with signed/unsigned overflow detection and optional saturation.
module chunked_add_sub
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic                  signed_mode,
  input  logic                  saturate,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  busy,
  output logic                  complete
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
      $error("chunked_add_sub: CHUNK_WIDTH must divide DATA_WIDTH");
    end
    if (DATA_WIDTH > MAX_WIDTH) begin : g_too_wide
      $error("chunked_add_sub: DATA_WIDTH exceeds arith_pkg::MAX_WIDTH");
    end
  endgenerate

  state_t                  state_q;
  op_cfg_t                 cfg_q;
  logic [DATA_WIDTH-1:0]   opA_q;
  logic [DATA_WIDTH-1:0]   opB_q;
  logic                    carry_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   partSum_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    carryOut_q;
  logic                    overflow_q;
  logic                    busy_q;
  logic                    complete_q;

  logic [CHUNK_WIDTH-1:0]  chunkA;
  logic [CHUNK_WIDTH-1:0]  chunkB;
  logic [CHUNK_WIDTH-1:0]  chunkSum;
  logic                    chunkCarry;
  logic [DATA_WIDTH-1:0]   sumFull_d;
  logic                    overflow_d;
  logic [DATA_WIDTH-1:0]   satVal_d;
  logic [DATA_WIDTH-1:0]   result_d;

  assign chunkA = opA_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign chunkB = opB_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];

  adder_chunk #(
    .WIDTH(CHUNK_WIDTH)
  ) u_chunk (
    .a_i    (chunkA),
    .b_i    (chunkB),
    .carry_i(carry_q),
    .sum_o  (chunkSum),
    .carry_o(chunkCarry)
  );

  // Full raw sum as it stands once the current chunk is merged in; only complete on the last chunk.
  always_comb begin
    sumFull_d = partSum_q;
    sumFull_d[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = chunkSum;
  end

  // opB_q already holds the inverted subtrahend, so the signed rule is identical for add and sub.
  always_comb begin
    overflow_d = 1'b0;
    if (cfg_q.signed_mode) begin
      overflow_d = (opA_q[DATA_WIDTH-1] == opB_q[DATA_WIDTH-1]) &&
                   (sumFull_d[DATA_WIDTH-1] != opA_q[DATA_WIDTH-1]);
    end else begin
      overflow_d = cfg_q.op_sub ? ~chunkCarry : chunkCarry;
    end
  end

  assign satVal_d = DATA_WIDTH'(sat_value(cfg_q.signed_mode, cfg_q.op_sub,
                                          opA_q[DATA_WIDTH-1], DATA_WIDTH));
  assign result_d = (cfg_q.saturate && overflow_d) ? satVal_d : sumFull_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      partSum_q  <= '0;
      result_q   <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opA_q             <= operand_a;
            opB_q             <= op_sub ? ~operand_b : operand_b;
            cfg_q.op_sub      <= op_sub;
            cfg_q.signed_mode <= signed_mode;
            cfg_q.saturate    <= saturate;
            carry_q           <= op_sub;
            idx_q             <= '0;
            partSum_q         <= '0;
            busy_q            <= 1'b1;
            state_q           <= RUN;
          end
        end
        RUN: begin
          partSum_q <= sumFull_d;
          carry_q   <= chunkCarry;
          idx_q     <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            result_q   <= result_d;
            carryOut_q <= chunkCarry;
            overflow_q <= overflow_d;
            complete_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = carryOut_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign complete  = complete_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed scoreboard bench for chunked_add_sub (32-bit data, 8-bit chunks).
module tb_chunked_add_sub;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int LAT = DW / CW;

  logic          clock;
  logic          reset;
  logic          start;
  logic          op_sub;
  logic          signed_mode;
  logic          saturate;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [DW-1:0] result;
  logic          carry_out;
  logic          overflow;
  logic          busy;
  logic          complete;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          c;
    logic          o;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;

  chunked_add_sub #(
    .DATA_WIDTH (DW),
    .CHUNK_WIDTH(CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op_sub     (op_sub),
    .signed_mode(signed_mode),
    .saturate   (saturate),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .busy       (busy),
    .complete   (complete)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: one wide addition, then flags and clamping as the unit should produce them.
  function automatic expT model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic sub, input logic sgn, input logic sat);
    logic [DW:0]   full;
    logic [DW-1:0] be;
    expT           e;
    be    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, be} + {{DW{1'b0}}, sub};
    e.c   = full[DW];
    e.res = full[DW-1:0];
    if (sgn) e.o = (a[DW-1] == be[DW-1]) && (full[DW-1] != a[DW-1]);
    else     e.o = sub ? ~full[DW] : full[DW];
    if (sat && e.o) begin
      if (!sgn) e.res = sub ? 32'h0000_0000 : 32'hFFFF_FFFF;
      else      e.res = a[DW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic sub, input logic sgn, input logic sat, input expT e);
    start       = 1'b1;
    operand_a   = a;
    operand_b   = b;
    op_sub      = sub;
    signed_mode = sgn;
    saturate    = sat;
    sbQ.push_back(e);
  endtask

  // Called at the first negedge after the accepting edge (or later, with 'elapsed' edges already seen).
  task automatic waitComplete(input string tag, input int elapsed);
    int  cycles;
    expT e;
    cycles = elapsed;
    while (complete !== 1'b1 && cycles < 20) begin
      if (cycles < LAT) checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
      @(negedge clock);
      cycles++;
    end
    checkOutput({tag, ".latency"}, 64'(cycles), 64'(LAT));
    checkOutput({tag, ".busyDone"}, 64'(busy), 64'd0);
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, ".result"}, 64'(result), 64'(e.res));
      checkOutput({tag, ".carry"}, 64'(carry_out), 64'(e.c));
      checkOutput({tag, ".overflow"}, 64'(overflow), 64'(e.o));
    end
  endtask

  task automatic checkPulseEnd(input string tag);
    @(negedge clock);
    checkOutput({tag, ".pulse"}, 64'(complete), 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic sub, input logic sgn, input logic sat, input expT e);
    applyStimulus(a, b, sub, sgn, sat, e);
    @(negedge clock);
    start = 1'b0;
    waitComplete(tag, 0);
    checkPulseEnd(tag);
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    logic          rs, rg, rt;
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; signed_mode = 1'b0; saturate = 1'b0;
    operand_a = '0; operand_b = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst.result", 64'(result), 64'd0);
    checkOutput("rst.carry", 64'(carry_out), 64'd0);
    checkOutput("rst.overflow", 64'(overflow), 64'd0);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.complete", 64'(complete), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] unsigned arithmetic");
    runOp("uAddSmall", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0});
    runOp("uAddWrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1});
    runOp("uAddSat",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b1});
    runOp("uSubWrap",  32'd5, 32'd7, 1'b1, 1'b0, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b1});
    runOp("uSubSat",   32'd5, 32'd7, 1'b1, 1'b0, 1'b1, '{32'h0000_0000, 1'b0, 1'b1});
    runOp("uSubOk",    32'd7, 32'd5, 1'b1, 1'b0, 1'b0, '{32'h0000_0002, 1'b1, 1'b0});

    $display("[TB] signed arithmetic");
    runOp("sAddOvf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, '{32'h8000_0000, 1'b0, 1'b1});
    runOp("sAddSat",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b1});
    runOp("sSubSat",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, '{32'h8000_0000, 1'b1, 1'b1});
    runOp("sSubNeg",   32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0, '{32'h0000_0002, 1'b1, 1'b0});

    $display("[TB] start while busy");
    applyStimulus(32'd10, 32'd20, 1'b0, 1'b0, 1'b0, '{32'd30, 1'b0, 1'b0});
    @(negedge clock);
    start = 1'b1; operand_a = 32'hFFFF_0000; operand_b = 32'h0000_1234; op_sub = 1'b1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    waitComplete("noise", 2);
    checkPulseEnd("noise");
    checkOutput("noise.idle", 64'(busy), 64'd0);

    $display("[TB] back-to-back start in complete cycle");
    applyStimulus(32'd100, 32'd1, 1'b0, 1'b0, 1'b0, '{32'd101, 1'b0, 1'b0});
    @(negedge clock);
    start = 1'b0;
    waitComplete("b2bFirst", 0);
    applyStimulus(32'hAAAA_0000, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, '{32'hAAA9_0001, 1'b1, 1'b0});
    @(negedge clock);
    start = 1'b0;
    waitComplete("b2bSecond", 0);
    checkPulseEnd("b2bSecond");

    $display("[TB] asynchronous reset mid-operation");
    start = 1'b1; operand_a = 32'hFFFF_FFFF; operand_b = 32'h0000_0001;
    op_sub = 1'b0; signed_mode = 1'b0; saturate = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRst.result", 64'(result), 64'd0);
    checkOutput("asyncRst.carry", 64'(carry_out), 64'd0);
    checkOutput("asyncRst.overflow", 64'(overflow), 64'd0);
    checkOutput("asyncRst.busy", 64'(busy), 64'd0);
    checkOutput("asyncRst.complete", 64'(complete), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    runOp("afterRst", 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, '{32'd2, 1'b0, 1'b0});

    $display("[TB] random operations against model");
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rg = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      runOp("rand", ra, rb, rs, rg, rt, model(ra, rb, rs, rg, rt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
